// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Imported by the bus interface and the sequencer.
package alu_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Passes through the 4-bit ALU needed for an operand of the given width
    function automatic int nibbles_for(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response and alu4bit-facing signal bundle for the sequencer.
// "slave" is the sequencer's view; "master" is the surrounding logic's view.
interface alu_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    import alu_seq_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [WIDTH-1:0]    req_a;
    logic [WIDTH-1:0]    req_b;
    logic [3:0]          req_s;
    logic                req_m;
    logic                req_cin;

    logic [NIBBLE_W-1:0] alu_a;
    logic [NIBBLE_W-1:0] alu_b;
    logic [3:0]          alu_s;
    logic                alu_m;
    logic                alu_cin;
    logic [NIBBLE_W-1:0] alu_f;
    logic                alu_cout;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDTH-1:0]    rsp_f;
    logic                rsp_cout;
    logic                rsp_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_s, req_m, req_cin,
        output req_ready,
        output alu_a, alu_b, alu_s, alu_m, alu_cin,
        input  alu_f, alu_cout,
        output rsp_valid, rsp_f, rsp_cout, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_s, req_m, req_cin,
        input  req_ready,
        input  alu_a, alu_b, alu_s, alu_m, alu_cin,
        output alu_f, alu_cout,
        input  rsp_valid, rsp_f, rsp_cout, rsp_zero,
        output rsp_ready
    );

endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs a WIDTH-bit ALU operation through an external 4-bit alu4bit, one nibble
// per cycle, rippling the carry between nibbles through a register.
import alu_seq_pkg::*;

module alu_nibble_sequencer #(
    parameter int WIDTH = 16   // multiple of 4, at least 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_nibble_sequencer_if.slave  bus
);

    localparam int NIBBLES = nibbles_for(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    seq_state_e          r_state;
    seq_state_e          w_state_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [3:0]          r_s;
    logic                r_m;
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;

    logic                w_accept;
    logic                w_run;
    logic [NIBBLE_W-1:0] w_a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] w_b_nib [NIBBLES];
    logic [WIDTH-1:0]    w_f;

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_run    = (r_state == RUN);

    // Operand slicing and per-nibble result capture; each result nibble is
    // written only on the pass whose index selects it.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            logic [NIBBLE_W-1:0] r_f_nib;

            assign w_a_nib[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
            assign w_b_nib[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];
            assign w_f[gi*NIBBLE_W +: NIBBLE_W] = r_f_nib;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_f_nib <= '0;
                end else if (w_accept) begin
                    r_f_nib <= '0;
                end else if (w_run && (r_idx == IDX_W'(gi))) begin
                    r_f_nib <= bus.alu_f;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_m     <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= bus.req_a;
                r_b     <= bus.req_b;
                r_s     <= bus.req_s;
                r_m     <= bus.req_m;
                r_carry <= bus.req_cin;
                r_idx   <= '0;
            end else if (w_run) begin
                // Carry chains in logic mode too; cout is taken exactly as the ALU gives it
                r_carry <= bus.alu_cout;
                if (r_idx != LAST_IDX) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        bus.req_ready = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_s     = '0;
        bus.alu_m     = 1'b0;
        bus.alu_cin   = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_f     = '0;
        bus.rsp_cout  = 1'b0;
        bus.rsp_zero  = 1'b0;

        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                bus.alu_a   = w_a_nib[r_idx];
                bus.alu_b   = w_b_nib[r_idx];
                bus.alu_s   = r_s;
                bus.alu_m   = r_m;
                bus.alu_cin = r_carry;
                if (r_idx == LAST_IDX) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // Response is held from registers, so it cannot move until accepted
                bus.rsp_valid = 1'b1;
                bus.rsp_f     = w_f;
                bus.rsp_cout  = r_carry;
                bus.rsp_zero  = (w_f == '0);
                if (bus.rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer at WIDTH=16 with a behavioural
// alu4bit (adder stub for arithmetic, 74181-style function table for logic).
module tb_alu_nibble_sequencer;

    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    logic use_real_alu;

    int checks;
    int failures;
    int cyc;

    alu_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_nibble_sequencer #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logic-mode function table of the 4-bit ALU; its carry out is not used in logic mode
    function automatic logic [3:0] alu_logic(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] s);
        case (s)
            4'd0:  return ~a;
            4'd1:  return ~(a | b);
            4'd2:  return ~a & b;
            4'd3:  return 4'h0;
            4'd4:  return ~(a & b);
            4'd5:  return ~b;
            4'd6:  return a ^ b;
            4'd7:  return a & ~b;
            4'd8:  return ~a | b;
            4'd9:  return ~(a ^ b);
            4'd10: return b;
            4'd11: return a & b;
            4'd12: return 4'hF;
            4'd13: return a | ~b;
            4'd14: return a | b;
            default: return a;
        endcase
    endfunction

    always_comb begin
        logic [4:0] sum;
        sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_cin};
        if (use_real_alu && bus.alu_m) begin
            bus.alu_f    = alu_logic(bus.alu_a, bus.alu_b, bus.alu_s);
            bus.alu_cout = 1'b0;
        end else begin
            bus.alu_f    = sum[3:0];
            bus.alu_cout = sum[4];
        end
    end

    // Cycle counter plus accept/response monitors for the back-to-back test
    logic        mon_en;
    int          acc_q[$];
    logic [15:0] rsp_q[$];
    logic        rspc_q[$];

    always @(posedge clk) begin
        if (mon_en && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
        if (mon_en && bus.rsp_valid && bus.rsp_ready) begin
            rsp_q.push_back(bus.rsp_f);
            rspc_q.push_back(bus.rsp_cout);
        end
        cyc = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] got_f;
    logic        got_cout;
    logic        got_zero;
    int          got_lat;
    logic [3:0]  got_cins;
    logic        got_sm_ok;

    // Issue one request from IDLE and wait (bounded) for rsp_valid; leaves the DUT in DONE
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] s, input logic m, input logic cin);
        int acc;
        int n;
        check_eq({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_s     = s;
        bus.req_m     = m;
        bus.req_cin   = cin;
        @(negedge clk);
        acc           = cyc;
        bus.req_valid = 1'b0;
        bus.req_a     = ~a;
        bus.req_b     = ~b;
        n             = 0;
        got_cins      = '0;
        got_sm_ok     = 1'b1;
        while (!bus.rsp_valid && n < 20) begin
            if (n < 4) got_cins[n] = bus.alu_cin;
            if (bus.alu_s !== s || bus.alu_m !== m) got_sm_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        got_lat  = cyc - acc;
        got_f    = bus.rsp_f;
        got_cout = bus.rsp_cout;
        got_zero = bus.rsp_zero;
        $display("op %s a=%h b=%h s=%h m=%b cin=%b -> f=%h cout=%b zero=%b lat=%0d",
                 tag, a, b, s, m, cin, got_f, got_cout, got_zero, got_lat);
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq({tag, ".rsp_valid_after"}, 32'(bus.rsp_valid), 32'd0);
        check_eq({tag, ".req_ready_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp6_f [3];
        logic        exp6_c [3];
        logic [15:0] op6_a  [3];
        logic [15:0] op6_b  [3];
        logic        op6_ci [3];
        int          guard;

        checks        = 0;
        failures      = 0;
        cyc           = 0;
        mon_en        = 1'b0;
        use_real_alu  = 1'b0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_s     = '0;
        bus.req_m     = 1'b0;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset.req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("reset.rsp_f", 32'(bus.rsp_f), 32'd0);
        check_eq("reset.alu_a", 32'(bus.alu_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: carry ripples out of nibble 0 and nibble 1
        run_op("t1", 16'h00FF, 16'h0001, 4'h0, 1'b0, 1'b0);
        check_eq("t1.f", 32'(got_f), 32'h0100);
        check_eq("t1.cout", 32'(got_cout), 32'd0);
        check_eq("t1.zero", 32'(got_zero), 32'd0);
        check_eq("t1.cin_seq", 32'(got_cins), 32'b0110);
        finish_rsp("t1");

        // 2: full overflow to zero, latency
        run_op("t2", 16'hFFFF, 16'h0001, 4'h0, 1'b0, 1'b0);
        check_eq("t2.f", 32'(got_f), 32'h0000);
        check_eq("t2.cout", 32'(got_cout), 32'd1);
        check_eq("t2.zero", 32'(got_zero), 32'd1);
        check_eq("t2.latency", 32'(got_lat), 32'd4);
        check_eq("t2.cin_seq", 32'(got_cins), 32'b1110);
        finish_rsp("t2");

        // 3: logic mode F=A, select/mode held through RUN
        use_real_alu = 1'b1;
        run_op("t3", 16'h3C5A, 16'h9999, 4'b1111, 1'b1, 1'b0);
        check_eq("t3.f", 32'(got_f), 32'h3C5A);
        check_eq("t3.cout", 32'(got_cout), 32'd0);
        check_eq("t3.sm_const", 32'(got_sm_ok), 32'd1);
        finish_rsp("t3");

        run_op("t3x", 16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b0);
        check_eq("t3x.f_xor", 32'(got_f), 32'h0FF0);
        finish_rsp("t3x");

        run_op("t3z", 16'h1234, 16'h5678, 4'd3, 1'b1, 1'b1);
        check_eq("t3z.f_zero", 32'(got_f), 32'h0000);
        check_eq("t3z.zero", 32'(got_zero), 32'd1);
        finish_rsp("t3z");
        use_real_alu = 1'b0;

        // 4: hold in DONE, requests while busy are ignored
        run_op("t4", 16'h1234, 16'h4321, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus.req_valid = 1'b1;
                bus.req_a     = 16'hDEAD;
                bus.req_b     = 16'hBEEF;
            end
            if (k == 3) bus.req_valid = 1'b0;
            check_eq($sformatf("t4.hold%0d.valid", k), 32'(bus.rsp_valid), 32'd1);
            check_eq($sformatf("t4.hold%0d.f", k), 32'(bus.rsp_f), 32'h5556);
            check_eq($sformatf("t4.hold%0d.cout", k), 32'(bus.rsp_cout), 32'd0);
            check_eq($sformatf("t4.hold%0d.req_ready", k), 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        finish_rsp("t4");
        @(negedge clk);
        check_eq("t4.no_latch_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("t4.no_latch_alu_a", 32'(bus.alu_a), 32'd0);

        // 5: reset in the middle of RUN
        bus.req_valid = 1'b1;
        bus.req_a     = 16'hABCD;
        bus.req_b     = 16'h0000;
        bus.req_cin   = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t5.idx2_alu_a", 32'(bus.alu_a), 32'hB);
        rst_n = 1'b0;
        #1;
        check_eq("t5.rst.req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("t5.rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("t5.rst.alu_a", 32'(bus.alu_a), 32'd0);
        check_eq("t5.rst.alu_cin", 32'(bus.alu_cin), 32'd0);
        check_eq("t5.rst.rsp_f", 32'(bus.rsp_f), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t5.no_rsp", 32'(bus.rsp_valid), 32'd0);
        run_op("t5b", 16'h0F0F, 16'h0101, 4'h0, 1'b0, 1'b1);
        check_eq("t5b.f", 32'(got_f), 32'h1011);
        check_eq("t5b.cout", 32'(got_cout), 32'd0);
        finish_rsp("t5b");

        // 6: back-to-back with rsp_ready tied high
        op6_a[0] = 16'h1234; op6_b[0] = 16'h1111; op6_ci[0] = 1'b0; exp6_f[0] = 16'h2345; exp6_c[0] = 1'b0;
        op6_a[1] = 16'h8000; op6_b[1] = 16'h8000; op6_ci[1] = 1'b1; exp6_f[1] = 16'h0001; exp6_c[1] = 1'b1;
        op6_a[2] = 16'hABCD; op6_b[2] = 16'h0000; op6_ci[2] = 1'b0; exp6_f[2] = 16'hABCD; exp6_c[2] = 1'b0;
        mon_en        = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1;
            bus.req_a     = op6_a[i];
            bus.req_b     = op6_b[i];
            bus.req_cin   = op6_ci[i];
            guard         = 0;
            while (!bus.req_ready && guard < 20) begin
                guard++;
                @(negedge clk);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        guard = 0;
        while (rsp_q.size() < 3 && guard < 30) begin
            guard++;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        mon_en        = 1'b0;
        check_eq("t6.accepts", 32'(acc_q.size()), 32'd3);
        check_eq("t6.responses", 32'(rsp_q.size()), 32'd3);
        if (acc_q.size() == 3) begin
            check_eq("t6.spacing01", 32'(acc_q[1] - acc_q[0]), 32'd6);
            check_eq("t6.spacing12", 32'(acc_q[2] - acc_q[1]), 32'd6);
        end
        if (rsp_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                $display("op t6.%0d a=%h b=%h cin=%b -> f=%h cout=%b",
                         i, op6_a[i], op6_b[i], op6_ci[i], rsp_q[i], rspc_q[i]);
                check_eq($sformatf("t6.f%0d", i), 32'(rsp_q[i]), 32'(exp6_f[i]));
                check_eq($sformatf("t6.cout%0d", i), 32'(rspc_q[i]), 32'(exp6_c[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
